ex_op_clz_norm: RTL
===================

// Module: ex_op_clz_norm
// PURPOSE
//  - Two-stage normaliser downstream of the CLZ unit in the EX path: takes operand + leading-zero count (0..64).
//  - Left-justifies operand (leading one to bit 63), produces biased FP exponent; feeds int->FP convert / FP repack.
//  - Stalls in lockstep with EX pipeline via exHold.
// PARAMETERS
//  - EXP_W     11    exponent output width
//  - EXP_BIAS  1023  exponent bias added to (msb_index)
// PORTS
//  - clock      in   1      core clock
//  - reset      in   1      async reset, active-high
//  - exHold     in   1      pipeline stall; 1 = freeze all stage registers
//  - inValid    in   1      operand/count valid this cycle
//  - inIs32     in   1      1 = 32-bit source in valRs[63:32]; valRs[31:0] ignored
//  - valRs      in   64     operand, same layout CLZ unit consumed
//  - clzCnt     in   8      leading-zero count from CLZ unit; 64 = zero operand
//  - outValid   out  1      result valid
//  - outMant    out  64     normalised mantissa, bit 63 = leading one
//  - outExp     out  EXP_W  biased exponent
//  - outZero    out  1      operand was zero
//  - outInexact out  1      any of outMant pre-round bits [10:0] set (bits lost to 53-bit mantissa)
// BEHAVIOUR
//  - Reset (async, immediate): all stage regs and all outputs = 0, incl. outValid.
//  - Latency 2 cycles: capture when inValid & !exHold at edge N -> outputs valid after edge N+2.
//  - Stage 1 (S1): if inIs32 force valRs[31:0]=0; coarse shift left by clzCnt[5:4]*16; reg clzCnt[3:0], is32, zero.
//  - Stage 2 (S2): fine shift by clzCnt[3:0]; exp = EXP_BIAS + (inIs32 ? 31 : 63) - clzCnt; EXP_W-bit result.
//  - zero = clzCnt[6] | (inIs32 & clzCnt>=32); if zero: outMant=0, outExp=0, outZero=1, outInexact=0.
//  - clzCnt>64 illegal; treated as zero, no error flag.
//  - exHold=1: every S1/S2 register incl. valid bits holds; inputs ignored; outputs stable.
//  - exHold=0: valid shifts S1->S2->out each cycle; bubbles (inValid=0) propagate as outValid=0, data don't-care.
//  - Back-to-back: one new operand per cycle when not held; no internal backpressure.
//  - Reset mid-operation: in-flight ops discarded; after reset release no stray outValid.
// CONFIGURATION
//  - Macro EXOP_CLZNORM_ROUND_EN.
//  - Defined: S2 rounds to 53-bit mantissa, RNE: guard=bit10, sticky=|bits[9:0], lsb=bit11;
//    round-up carry-out -> outMant=64'h8000_0000_0000_0000, outExp+1; outMant[10:0]=0 always.
//  - Undefined: truncate; outMant[10:0]=0, outExp unadjusted. outInexact computed identically both ways.
//  - Latency unchanged (2) in both configurations.
// STRUCTURE
//  - Shared package: exponent bias/width constants, 53-bit mantissa width, round-bit positions,
//    64-bit all-ones/zero constants already used by the EX units.
//  - One sub-module: ex_op_norm_rnd (53-bit RNE incrementer + carry/exp adjust), instantiated only under macro.
//  - Top holds S1/S2 registers, hold muxing, exponent arithmetic.
// TESTING
//  - valRs=64'h1, clzCnt=63, inIs32=0 -> 2 cycles later outValid=1, outMant=64'h8000_0000_0000_0000, outExp=11'h3FF.
//  - clzCnt=64 -> outZero=1, outMant=0, outExp=0, outInexact=0.
//  - inIs32=1, valRs=64'h0000_0100_FFFF_FFFF, clzCnt=23 -> outMant=64'h8000_0000_0000_0000, outExp=11'h407.
//  - valRs=64'hFFFF_FFFF_FFFF_FFFF, clzCnt=0: ROUND_EN -> outMant=64'h8000_0000_0000_0000, outExp=11'h43F, inexact=1;
//    without -> outMant=64'hFFFF_FFFF_FFFF_F800, outExp=11'h43E, inexact=1.
//  - inValid pulse then exHold=1 for 3 cycles -> outputs frozen; result appears 2 unheld edges after capture.
//  - reset asserted with op in S1 -> outValid=0 immediately, stays 0 after release until next inValid.

Source files
------------

// File: rtl/ex_op_clz_norm_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : ex_op_clz_norm_pkg                                              |
// | Desc     : Shared constants for the EX-path CLZ normaliser and rounder.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

package ex_op_clz_norm_pkg;

  localparam int c_expW     = 11;
  localparam int c_expBias  = 1023;
  localparam int c_dataW    = 64;
  localparam int c_mantW    = 53;
  // Bits below the 53-bit mantissa: lsb of the kept field, then guard, then sticky.
  localparam int c_lsbBit   = c_dataW - c_mantW;
  localparam int c_guardBit = c_lsbBit - 1;

  localparam logic [63:0] c_allOnes  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] c_allZeros = 64'h0000_0000_0000_0000;
  localparam logic [63:0] c_mantOne  = 64'h8000_0000_0000_0000;

endpackage

`default_nettype wire

// File: rtl/ex_op_norm_rnd.sv
// +----------------------------------------------------------------------------+
// | Module   : ex_op_norm_rnd                                                  |
// | Desc     : Round-to-nearest-even of a left-justified 64-bit value to a     |
// |            53-bit mantissa, with carry-out exponent adjust.                |
// |            Present only when EXOP_CLZNORM_ROUND_EN is defined.             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

`ifdef EXOP_CLZNORM_ROUND_EN
module ex_op_norm_rnd
  import ex_op_clz_norm_pkg::*;
#(
  parameter int EXP_W = c_expW
) (
  input  logic [63:0]      normIn,
  input  logic [EXP_W-1:0] expIn,
  output logic [63:0]      mantOut,
  output logic [EXP_W-1:0] expOut
);

  logic             w_lsb;
  logic             w_guard;
  logic             w_sticky;
  logic             w_roundUp;
  logic [c_mantW:0] w_sum;

  assign w_lsb     = normIn[c_lsbBit];
  assign w_guard   = normIn[c_guardBit];
  assign w_sticky  = |normIn[c_guardBit-1:0];
  assign w_roundUp = w_guard & (w_sticky | w_lsb);

  assign w_sum = {1'b0, normIn[63:c_lsbBit]} + {{c_mantW{1'b0}}, w_roundUp};

  // A carry out of the all-ones mantissa renormalises to 1.0 at the next binade.
  assign mantOut = w_sum[c_mantW] ? c_mantOne : {w_sum[c_mantW-1:0], {c_lsbBit{1'b0}}};
  assign expOut  = expIn + EXP_W'(w_sum[c_mantW]);

endmodule
`endif

`default_nettype wire

// File: rtl/ex_op_clz_norm.sv
// +----------------------------------------------------------------------------+
// | Module   : ex_op_clz_norm                                                  |
// | Desc     : Two-stage normaliser after the CLZ unit: left-justifies the     |
// |            operand and forms the biased exponent. Optional RNE rounding    |
// |            to 53 bits via macro EXOP_CLZNORM_ROUND_EN.                     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module ex_op_clz_norm
  import ex_op_clz_norm_pkg::*;
#(
  parameter int EXP_W    = c_expW,
  parameter int EXP_BIAS = c_expBias
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             exHold,
  input  logic             inValid,
  input  logic             inIs32,
  input  logic [63:0]      valRs,
  input  logic [7:0]       clzCnt,
  output logic             outValid,
  output logic [63:0]      outMant,
  output logic [EXP_W-1:0] outExp,
  output logic             outZero,
  output logic             outInexact
);

  logic             w_s1Zero;
  logic [63:0]      w_s1Op;
  logic [63:0]      w_s1Coarse;
  logic [EXP_W-1:0] w_s1Exp;

  logic             r_s1Valid;
  logic [63:0]      r_s1Mant;
  logic [3:0]       r_s1Fine;
  logic [EXP_W-1:0] r_s1Exp;
  logic             r_s1Zero;

  logic             r_s2Valid;
  logic [63:0]      r_s2Norm;
  logic [EXP_W-1:0] r_s2Exp;
  logic             r_s2Zero;

  logic [63:0]      w_mant;
  logic [EXP_W-1:0] w_exp;
  logic             w_inexact;

  logic             r_outValid;
  logic [63:0]      r_outMant;
  logic [EXP_W-1:0] r_outExp;
  logic             r_outZero;
  logic             r_outInexact;

  // Counts above 64 are illegal and fold into the zero case.
  assign w_s1Zero   = clzCnt[7] | clzCnt[6] | (inIs32 & clzCnt[5]);
  assign w_s1Op     = inIs32 ? {valRs[63:32], 32'h0000_0000} : valRs;
  assign w_s1Coarse = w_s1Op << {clzCnt[5:4], 4'h0};
  assign w_s1Exp    = EXP_W'(EXP_BIAS) + (inIs32 ? EXP_W'(31) : EXP_W'(63)) - EXP_W'(clzCnt);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1Valid <= 1'b0;
      r_s1Mant  <= c_allZeros;
      r_s1Fine  <= 4'h0;
      r_s1Exp   <= '0;
      r_s1Zero  <= 1'b0;
    end else if (!exHold) begin
      r_s1Valid <= inValid;
      r_s1Mant  <= w_s1Coarse;
      r_s1Fine  <= clzCnt[3:0];
      r_s1Exp   <= w_s1Exp;
      r_s1Zero  <= w_s1Zero;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s2Valid <= 1'b0;
      r_s2Norm  <= c_allZeros;
      r_s2Exp   <= '0;
      r_s2Zero  <= 1'b0;
    end else if (!exHold) begin
      r_s2Valid <= r_s1Valid;
      r_s2Norm  <= r_s1Mant << r_s1Fine;
      r_s2Exp   <= r_s1Exp;
      r_s2Zero  <= r_s1Zero;
    end
  end

  // Inexact reflects the bits below the 53-bit mantissa, independent of rounding.
  assign w_inexact = |r_s2Norm[c_guardBit:0];

`ifdef EXOP_CLZNORM_ROUND_EN
  ex_op_norm_rnd #(
    .EXP_W (EXP_W)
  ) u_rnd (
    .normIn  (r_s2Norm),
    .expIn   (r_s2Exp),
    .mantOut (w_mant),
    .expOut  (w_exp)
  );
`else
  assign w_mant = r_s2Norm & (c_allOnes << c_lsbBit);
  assign w_exp  = r_s2Exp;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_outValid   <= 1'b0;
      r_outMant    <= c_allZeros;
      r_outExp     <= '0;
      r_outZero    <= 1'b0;
      r_outInexact <= 1'b0;
    end else if (!exHold) begin
      r_outValid   <= r_s2Valid;
      r_outMant    <= r_s2Zero ? c_allZeros : w_mant;
      r_outExp     <= r_s2Zero ? '0 : w_exp;
      r_outZero    <= r_s2Zero;
      r_outInexact <= ~r_s2Zero & w_inexact;
    end
  end

  assign outValid   = r_outValid;
  assign outMant    = r_outMant;
  assign outExp     = r_outExp;
  assign outZero    = r_outZero;
  assign outInexact = r_outInexact;

endmodule

`default_nettype wire
